// File: rtl/multi_alarm.sv
// Multi-channel alarm: editable H:M:S and enable per channel, button lockout, match/ring/snooze/timeout.
// The buzzer output is named buzz because "do" is a reserved word in SystemVerilog.
module multi_alarm #(
  parameter int N_ALARMS   = 4,
  parameter int MODE_ID    = 5,
  parameter int LOCKOUT    = 2000,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int SW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                newclk,
  input  logic                rst_n,
  input  logic [5:0]          mode,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic                middle,
  input  logic [10:0]         hour,
  input  logic [10:0]         minute,
  input  logic [10:0]         second,
  input  logic                sec_tick,
  input  logic                switch,
  input  logic                snooze,
  input  logic                ext_trig,
  output logic [2:0]          alarm_mode,
  output logic [SW-1:0]       sel,
  output logic [10:0]         temp_hour,
  output logic [10:0]         temp_minute,
  output logic [10:0]         temp_second,
  output logic [N_ALARMS-1:0] en_mask,
  output logic                buzz,
  output logic [SW-1:0]       ring_id,
  output logic                snoozing
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEC  = 3'd1;
  localparam logic [2:0] ST_MIN  = 3'd2;
  localparam logic [2:0] ST_HOUR = 3'd3;
  localparam logic [SW-1:0] SEL_TOP = SW'(N_ALARMS - 1);

  logic [N_ALARMS-1:0][10:0] t_h, t_m, t_s;
  logic [N_ALARMS-1:0][10:0] nxt_h, nxt_m, nxt_s;
  logic [N_ALARMS-1:0]       nxt_en, hit;
  logic [2:0]                nxt_am;
  logic [SW-1:0]             nxt_sel, hit_id, nxt_rid;
  logic                      lock, any_btn, acc, mode_on, match_ok;
  logic [31:0]               lk_cnt, rcnt, scnt, nxt_rcnt, nxt_scnt;
  logic                      nxt_buzz, nxt_snz, snz_exp;

  function automatic logic [10:0] fwd(input logic [10:0] v, input logic [10:0] top);
    return (v >= top) ? 11'd0 : v + 11'd1;
  endfunction

  function automatic logic [10:0] back(input logic [10:0] v, input logic [10:0] top);
    return (v == 11'd0) ? top : v - 11'd1;
  endfunction

  assign mode_on = (mode == 6'(MODE_ID));
  assign any_btn = up | down | left | right | middle;
  assign acc     = mode_on && !lock && any_btn;

  // Lockout: set by an accepted press, cleared by LOCKOUT consecutive all-idle cycles.
  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      lock   <= 1'b0;
      lk_cnt <= '0;
    end else if (acc) begin
      lock   <= 1'b1;
      lk_cnt <= '0;
    end else if (lock) begin
      if (any_btn) lk_cnt <= '0;
      else if (lk_cnt + 32'd1 >= 32'(LOCKOUT)) begin
        lock   <= 1'b0;
        lk_cnt <= '0;
      end else lk_cnt <= lk_cnt + 32'd1;
    end
  end

  always_comb begin
    nxt_am  = mode_on ? alarm_mode : ST_IDLE;
    nxt_sel = sel;
    nxt_en  = en_mask;
    nxt_h   = t_h;
    nxt_m   = t_m;
    nxt_s   = t_s;
    if (acc) begin
      if (alarm_mode == ST_IDLE) begin
        if (middle) nxt_am = ST_SEC;
        else if (left) nxt_en[sel] = ~en_mask[sel];
        else if (!right) begin
          if (up) nxt_sel = (sel == SEL_TOP) ? '0 : sel + 1'b1;
          else if (down) nxt_sel = (sel == '0) ? SEL_TOP : sel - 1'b1;
        end
      end else begin
        if (middle) nxt_am = ST_IDLE;
        else if (left) begin
          case (alarm_mode)
            ST_SEC:  nxt_am = ST_MIN;
            ST_MIN:  nxt_am = ST_HOUR;
            default: nxt_am = ST_SEC;
          endcase
        end else if (right) begin
          case (alarm_mode)
            ST_SEC:  nxt_am = ST_HOUR;
            ST_HOUR: nxt_am = ST_MIN;
            default: nxt_am = ST_SEC;
          endcase
        end else begin
          case (alarm_mode)
            ST_SEC:  nxt_s[sel] = up ? fwd(t_s[sel], 11'd59) : back(t_s[sel], 11'd59);
            ST_MIN:  nxt_m[sel] = up ? fwd(t_m[sel], 11'd59) : back(t_m[sel], 11'd59);
            default: nxt_h[sel] = up ? fwd(t_h[sel], 11'd23) : back(t_h[sel], 11'd23);
          endcase
        end
      end
    end
  end

  for (genvar k = 0; k < N_ALARMS; k++) begin : g_hit
    assign hit[k] = en_mask[k] && (t_h[k] == hour) && (t_m[k] == minute) && (t_s[k] == second);
  end

  always_comb begin
    hit_id = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--)
      if (hit[k]) hit_id = SW'(k);
  end

  assign match_ok = sec_tick && (alarm_mode == ST_IDLE) && (|hit);
  assign snz_exp  = snoozing && sec_tick && (scnt <= 32'd1);

  // Ring events in priority order: switch, snooze, snooze expiry, match, ext_trig, timeout.
  always_comb begin
    nxt_buzz = buzz;
    nxt_rid  = ring_id;
    nxt_snz  = snoozing;
    nxt_rcnt = rcnt;
    nxt_scnt = scnt;
    if (snoozing && sec_tick && scnt > 32'd1) nxt_scnt = scnt - 32'd1;
    if (switch) begin
      nxt_buzz = 1'b0;
      nxt_snz  = 1'b0;
    end else if (snooze && buzz) begin
      nxt_buzz = 1'b0;
      nxt_snz  = 1'b1;
      nxt_scnt = 32'(SNOOZE_SEC);
    end else if (snz_exp) begin
      nxt_snz  = 1'b0;
      nxt_scnt = '0;
      nxt_buzz = 1'b1;
      nxt_rcnt = 32'(RING_SEC);
    end else if (match_ok) begin
      nxt_buzz = 1'b1;
      nxt_rid  = hit_id;
      nxt_snz  = 1'b0;
      nxt_rcnt = 32'(RING_SEC);
    end else if (ext_trig) begin
      nxt_buzz = 1'b1;
      nxt_rcnt = 32'(RING_SEC);
    end else if (buzz && sec_tick) begin
      if (rcnt <= 32'd1) begin
        nxt_buzz = 1'b0;
        nxt_rcnt = '0;
      end else nxt_rcnt = rcnt - 32'd1;
    end
  end

  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_mode  <= ST_IDLE;
      sel         <= '0;
      en_mask     <= '0;
      t_h         <= '0;
      t_m         <= '0;
      t_s         <= '0;
      temp_hour   <= '0;
      temp_minute <= '0;
      temp_second <= '0;
      buzz        <= 1'b0;
      ring_id     <= '0;
      snoozing    <= 1'b0;
      rcnt        <= '0;
      scnt        <= '0;
    end else begin
      alarm_mode  <= nxt_am;
      sel         <= nxt_sel;
      en_mask     <= nxt_en;
      t_h         <= nxt_h;
      t_m         <= nxt_m;
      t_s         <= nxt_s;
      temp_hour   <= nxt_h[nxt_sel];
      temp_minute <= nxt_m[nxt_sel];
      temp_second <= nxt_s[nxt_sel];
      buzz        <= nxt_buzz;
      ring_id     <= nxt_rid;
      snoozing    <= nxt_snz;
      rcnt        <= nxt_rcnt;
      scnt        <= nxt_scnt;
    end
  end

endmodule

// File: tb/tb_multi_alarm.sv
// Directed bench for multi_alarm: button/edit vectors from a table, hand sequences for ring/snooze/mode/reset.
module tb_multi_alarm;

  localparam logic [4:0] BM = 5'b10000, BL = 5'b01000, BR = 5'b00100, BU = 5'b00010, BD = 5'b00001;

  logic        newclk = 1'b0;
  logic        rst_n;
  logic [5:0]  mode;
  logic        up, down, left, right, middle;
  logic [10:0] hour, minute, second;
  logic        sec_tick, switch, snooze, ext_trig;
  logic [2:0]  alarm_mode;
  logic [1:0]  sel, ring_id;
  logic [10:0] temp_hour, temp_minute, temp_second;
  logic [3:0]  en_mask;
  logic        buzz, snoozing;

  int total = 0;
  int bad   = 0;

  multi_alarm #(.N_ALARMS(4), .MODE_ID(5), .LOCKOUT(4), .SNOOZE_SEC(3), .RING_SEC(60)) dut (
    .newclk(newclk), .rst_n(rst_n), .mode(mode),
    .up(up), .down(down), .left(left), .right(right), .middle(middle),
    .hour(hour), .minute(minute), .second(second), .sec_tick(sec_tick),
    .switch(switch), .snooze(snooze), .ext_trig(ext_trig),
    .alarm_mode(alarm_mode), .sel(sel),
    .temp_hour(temp_hour), .temp_minute(temp_minute), .temp_second(temp_second),
    .en_mask(en_mask), .buzz(buzz), .ring_id(ring_id), .snoozing(snoozing)
  );

  always #5 newclk = ~newclk;

  typedef struct {
    logic [4:0]  b;
    int          hold;
    int          idle;
    logic [2:0]  am;
    logic [1:0]  sel;
    logic [10:0] h, m, s;
    logic [3:0]  en;
  } vec_t;

  vec_t v[34];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge newclk);
    #1;
  endtask

  task automatic press(input logic [4:0] b, input int hold, input int idle);
    {middle, left, right, up, down} = b;
    for (int i = 0; i < hold; i++) tick();
    {middle, left, right, up, down} = 5'b0;
    for (int i = 0; i < idle; i++) tick();
  endtask

  task automatic chk_ring(input string nm, input logic eb, input logic [1:0] er, input logic es);
    chk({nm, ".buzz"}, 32'(buzz), 32'(eb));
    chk({nm, ".ring_id"}, 32'(ring_id), 32'(er));
    chk({nm, ".snoozing"}, 32'(snoozing), 32'(es));
  endtask

  initial begin
    // b, hold, idle, am, sel, h, m, s, en
    v[0]  = '{BM, 1, 4, 3'd1, 2'd0, 11'd0,  11'd0,  11'd0,  4'b0000};
    v[1]  = '{BU, 1, 4, 3'd1, 2'd0, 11'd0,  11'd0,  11'd1,  4'b0000};
    v[2]  = '{BU, 10,4, 3'd1, 2'd0, 11'd0,  11'd0,  11'd2,  4'b0000};
    v[3]  = '{BU, 1, 2, 3'd1, 2'd0, 11'd0,  11'd0,  11'd3,  4'b0000};
    v[4]  = '{BU, 1, 4, 3'd1, 2'd0, 11'd0,  11'd0,  11'd3,  4'b0000};
    v[5]  = '{BM, 1, 4, 3'd0, 2'd0, 11'd0,  11'd0,  11'd3,  4'b0000};
    v[6]  = '{BU, 1, 4, 3'd0, 2'd1, 11'd0,  11'd0,  11'd0,  4'b0000};
    v[7]  = '{BD, 1, 4, 3'd0, 2'd0, 11'd0,  11'd0,  11'd3,  4'b0000};
    v[8]  = '{BD, 1, 4, 3'd0, 2'd3, 11'd0,  11'd0,  11'd0,  4'b0000};
    v[9]  = '{BL, 1, 4, 3'd0, 2'd3, 11'd0,  11'd0,  11'd0,  4'b1000};
    v[10] = '{BM, 1, 4, 3'd1, 2'd3, 11'd0,  11'd0,  11'd0,  4'b1000};
    v[11] = '{BD, 1, 4, 3'd1, 2'd3, 11'd0,  11'd0,  11'd59, 4'b1000};
    v[12] = '{BU, 1, 4, 3'd1, 2'd3, 11'd0,  11'd0,  11'd0,  4'b1000};
    v[13] = '{BR, 1, 4, 3'd3, 2'd3, 11'd0,  11'd0,  11'd0,  4'b1000};
    v[14] = '{BD, 1, 4, 3'd3, 2'd3, 11'd23, 11'd0,  11'd0,  4'b1000};
    v[15] = '{BU, 1, 4, 3'd3, 2'd3, 11'd0,  11'd0,  11'd0,  4'b1000};
    v[16] = '{BD, 1, 4, 3'd3, 2'd3, 11'd23, 11'd0,  11'd0,  4'b1000};
    v[17] = '{BL, 1, 4, 3'd1, 2'd3, 11'd23, 11'd0,  11'd0,  4'b1000};
    v[18] = '{BL, 1, 4, 3'd2, 2'd3, 11'd23, 11'd0,  11'd0,  4'b1000};
    v[19] = '{BD, 1, 4, 3'd2, 2'd3, 11'd23, 11'd59, 11'd0,  4'b1000};
    v[20] = '{BR, 1, 4, 3'd1, 2'd3, 11'd23, 11'd59, 11'd0,  4'b1000};
    v[21] = '{BM, 1, 4, 3'd0, 2'd3, 11'd23, 11'd59, 11'd0,  4'b1000};
    v[22] = '{BU, 1, 4, 3'd0, 2'd0, 11'd0,  11'd0,  11'd3,  4'b1000};
    v[23] = '{BU, 1, 4, 3'd0, 2'd1, 11'd0,  11'd0,  11'd0,  4'b1000};
    v[24] = '{BL, 1, 4, 3'd0, 2'd1, 11'd0,  11'd0,  11'd0,  4'b1010};
    v[25] = '{BM, 1, 4, 3'd1, 2'd1, 11'd0,  11'd0,  11'd0,  4'b1010};
    v[26] = '{BD, 1, 4, 3'd1, 2'd1, 11'd0,  11'd0,  11'd59, 4'b1010};
    v[27] = '{BM, 1, 4, 3'd0, 2'd1, 11'd0,  11'd0,  11'd59, 4'b1010};
    v[28] = '{BU, 1, 4, 3'd0, 2'd2, 11'd0,  11'd0,  11'd0,  4'b1010};
    v[29] = '{BL, 1, 4, 3'd0, 2'd2, 11'd0,  11'd0,  11'd0,  4'b1110};
    v[30] = '{BM, 1, 4, 3'd1, 2'd2, 11'd0,  11'd0,  11'd0,  4'b1110};
    v[31] = '{BD, 1, 4, 3'd1, 2'd2, 11'd0,  11'd0,  11'd59, 4'b1110};
    v[32] = '{BM, 1, 4, 3'd0, 2'd2, 11'd0,  11'd0,  11'd59, 4'b1110};
    v[33] = '{BR, 1, 4, 3'd0, 2'd2, 11'd0,  11'd0,  11'd59, 4'b1110};

    rst_n = 1'b0; mode = 6'd5;
    {middle, left, right, up, down} = 5'b0;
    hour = 11'd0; minute = 11'd1; second = 11'd0;
    sec_tick = 1'b0; switch = 1'b0; snooze = 1'b0; ext_trig = 1'b0;
    #12;
    chk("reset.alarm_mode", 32'(alarm_mode), 32'd0);
    chk("reset.en_mask", 32'(en_mask), 32'd0);
    chk_ring("reset", 1'b0, 2'd0, 1'b0);
    @(negedge newclk);
    rst_n = 1'b1;
    tick();

    // Editing through the button table
    for (int i = 0; i < 34; i++) begin
      press(v[i].b, v[i].hold, v[i].idle);
      chk($sformatf("vec%0d.am", i),  32'(alarm_mode),  32'(v[i].am));
      chk($sformatf("vec%0d.sel", i), 32'(sel),         32'(v[i].sel));
      chk($sformatf("vec%0d.h", i),   32'(temp_hour),   32'(v[i].h));
      chk($sformatf("vec%0d.m", i),   32'(temp_minute), 32'(v[i].m));
      chk($sformatf("vec%0d.s", i),   32'(temp_second), 32'(v[i].s));
      chk($sformatf("vec%0d.en", i),  32'(en_mask),     32'(v[i].en));
    end

    // Ch1 and ch2 both match 0:00:59; lowest wins, then 60-tick timeout
    chk_ring("idle", 1'b0, 2'd0, 1'b0);
    minute = 11'd0; second = 11'd59; sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0; minute = 11'd1; second = 11'd0;
    chk_ring("match", 1'b1, 2'd1, 1'b0);
    sec_tick = 1'b1;
    for (int i = 0; i < 59; i++) tick();
    chk_ring("ring59", 1'b1, 2'd1, 1'b0);
    tick();
    sec_tick = 1'b0;
    chk_ring("timeout", 1'b0, 2'd1, 1'b0);

    // Snooze and re-ring after 3 ticks
    minute = 11'd0; second = 11'd59; sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0; minute = 11'd1; second = 11'd0;
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    chk_ring("snooze", 1'b0, 2'd1, 1'b1);
    sec_tick = 1'b1;
    tick(); tick();
    chk_ring("snooze2", 1'b0, 2'd1, 1'b1);
    tick();
    sec_tick = 1'b0;
    chk_ring("snz_exp", 1'b1, 2'd1, 1'b0);

    // Switch beats a simultaneous match, and holds buzz low
    switch = 1'b1; minute = 11'd0; second = 11'd59; sec_tick = 1'b1;
    tick();
    chk_ring("switch", 1'b0, 2'd1, 1'b0);
    tick();
    chk_ring("switch_hold", 1'b0, 2'd1, 1'b0);
    switch = 1'b0; sec_tick = 1'b0; minute = 11'd1;
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    chk_ring("snooze_idle", 1'b0, 2'd1, 1'b0);

    // ext_trig keeps ring_id; a new match re-latches it
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    chk_ring("ext_trig", 1'b1, 2'd1, 1'b0);
    hour = 11'd23; minute = 11'd59; second = 11'd0; sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0; hour = 11'd0; minute = 11'd1;
    chk_ring("relatch", 1'b1, 2'd3, 1'b0);
    switch = 1'b1;
    tick();
    switch = 1'b0;
    chk_ring("dismiss", 1'b0, 2'd3, 1'b0);

    // Leaving MODE_ID drops the editor to state 0 and blocks buttons
    press(BM, 1, 4);
    press(BR, 1, 4);
    chk("mode.am3", 32'(alarm_mode), 32'd3);
    mode = 6'd2;
    tick();
    chk("mode.exit", 32'(alarm_mode), 32'd0);
    press(BU, 1, 4);
    press(BM, 1, 4);
    chk("mode.sel_kept", 32'(sel), 32'd2);
    chk("mode.am_kept", 32'(alarm_mode), 32'd0);
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    chk_ring("mode.ext", 1'b1, 2'd3, 1'b0);

    // Asynchronous reset mid-edit
    mode = 6'd5;
    press(BU, 1, 4);
    press(BM, 1, 4);
    press(BL, 1, 4);
    chk("pre_rst.am", 32'(alarm_mode), 32'd2);
    chk("pre_rst.sel", 32'(sel), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.am", 32'(alarm_mode), 32'd0);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.en", 32'(en_mask), 32'd0);
    chk("rst.temp", 32'({temp_hour, temp_second}), 32'd0);
    chk_ring("rst", 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
